calc_ck: RTL and testbench

- Computes one correlation term C_k for the LABS (low-autocorrelation binary sequence) search engine.
- Bit-vectors a and b hold ±1 sequences: bit 1 = +1, bit 0 = −1. Typically b is a shifted copy of a.
- Output z = Σ a_i·b_i over SEQ_WIDTH positions, as an 8-bit two's-complement value, registered.
- Used as the leaf of the segmented pipelined C_k adder: several instances, partial sums added modulo 256.

---
 rtl/calc_ck_pkg.sv | 20 ++
 rtl/calc_ck_popcount.sv | 41 ++++
 rtl/calc_ck.sv | 42 ++++
 tb/tb_calc_ck.sv | 136 +++++++++++++
 4 files changed

// File: rtl/calc_ck_pkg.sv
// Shared constants and helpers for the LABS C_k correlation leaf.
// The popcount width and the result width are derived here.
package calc_ck_pkg;

    localparam int Z_WIDTH = 8;

    // Ceiling log2; used for the popcount width as clog2(width + 1).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/calc_ck_popcount.sv
// Combinational popcount built as a balanced adder tree.
// The module splits its input in halves and recurses until single bits remain.
module calc_ck_popcount
    import calc_ck_pkg::*;
#(
    parameter int WIDTH = 40
) (
    input  logic [WIDTH-1:0]             bits,
    output logic [clog2(WIDTH+1)-1:0]    count
);

    localparam int OUT_W = clog2(WIDTH + 1);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign count = bits;
        end else begin : g_split
            localparam int LO_W  = WIDTH / 2;
            localparam int HI_W  = WIDTH - LO_W;
            localparam int LO_CW = clog2(LO_W + 1);
            localparam int HI_CW = clog2(HI_W + 1);

            logic [LO_CW-1:0] lo_count;
            logic [HI_CW-1:0] hi_count;

            calc_ck_popcount #(.WIDTH(LO_W)) u_lo (
                .bits  (bits[LO_W-1:0]),
                .count (lo_count)
            );

            calc_ck_popcount #(.WIDTH(HI_W)) u_hi (
                .bits  (bits[WIDTH-1:LO_W]),
                .count (hi_count)
            );

            // Both halves are zero-extended to the full count width before adding.
            assign count = OUT_W'(lo_count) + OUT_W'(hi_count);
        end
    endgenerate

endmodule

// File: rtl/calc_ck.sv
// One C_k correlation term: z = SEQ_WIDTH - 2*popcount(a ^ b), registered.
// Partial sums from several instances are added modulo 256 downstream.
module calc_ck
    import calc_ck_pkg::*;
#(
    parameter int SEQ_WIDTH = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEQ_WIDTH-1:0] a,
    input  logic [SEQ_WIDTH-1:0] b,
    output logic [Z_WIDTH-1:0]   z
);

    localparam int M_W = clog2(SEQ_WIDTH + 1);

    logic [SEQ_WIDTH-1:0] diff;
    logic [M_W-1:0]       mismatches;
    logic [Z_WIDTH-1:0]   sum_next;
    logic [Z_WIDTH-1:0]   z_reg = '0;

    // A mismatching bit pair contributes -1 instead of +1, hence the factor of two.
    assign diff = a ^ b;

    calc_ck_popcount #(.WIDTH(SEQ_WIDTH)) u_popcount (
        .bits  (diff),
        .count (mismatches)
    );

    assign sum_next = Z_WIDTH'(SEQ_WIDTH) - (Z_WIDTH'(mismatches) << 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            z_reg <= '0;
        end else begin
            z_reg <= sum_next;
        end
    end

    assign z = z_reg;

endmodule

// File: tb/tb_calc_ck.sv
// Scoreboard bench for calc_ck: a 40-bit and a 20-bit instance run side by side.
// Expected sums are queued when inputs are driven and checked one edge later.
module tb_calc_ck;

    logic        clk;
    logic        rst;
    logic [39:0] a40;
    logic [39:0] b40;
    logic [19:0] a20;
    logic [19:0] b20;
    logic [7:0]  z40;
    logic [7:0]  z20;

    logic [7:0]  exp_q40[$];
    logic [7:0]  exp_q20[$];

    int checks;
    int failures;

    calc_ck #(.SEQ_WIDTH(40)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a40),
        .b   (b40),
        .z   (z40)
    );

    calc_ck #(.SEQ_WIDTH(20)) dut20 (
        .clk (clk),
        .rst (rst),
        .a   (a20),
        .b   (b20),
        .z   (z20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count mismatches bit by bit, then w - 2m modulo 256.
    function automatic logic [7:0] model(input int w, input logic [63:0] x);
        int m;
        m = 0;
        for (int i = 0; i < w; i++) begin
            if (x[i]) m = m + 1;
        end
        return 8'(w - 2 * m);
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] expected);
        checks = checks + 1;
        if (got !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s got=0x%02h (%0d) expected=0x%02h (%0d)",
                     tag, got, $signed(got), expected, $signed(expected));
        end
    endtask

    // Drive one cycle of inputs away from the edge, queue the expectations,
    // then check both instances just after the sampling edge.
    task automatic applyStimulus(input string tag, input logic rst_val,
                                 input logic [39:0] a_v, input logic [39:0] b_v,
                                 input logic [19:0] a2_v, input logic [19:0] b2_v);
        logic [7:0] e40;
        logic [7:0] e20;
        @(negedge clk);
        rst = rst_val;
        a40 = a_v;
        b40 = b_v;
        a20 = a2_v;
        b20 = b2_v;
        exp_q40.push_back(rst_val ? model(40, {24'd0, a_v ^ b_v}) : 8'h00);
        exp_q20.push_back(rst_val ? model(20, {44'd0, a2_v ^ b2_v}) : 8'h00);
        @(posedge clk);
        #1;
        if (exp_q40.size() == 0 || exp_q20.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 8'hxx, 8'h00);
        end else begin
            e40 = exp_q40.pop_front();
            e20 = exp_q20.pop_front();
            checkOutput({tag, "_w40"}, z40, e40);
            checkOutput({tag, "_w20"}, z20, e20);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        a40 = '0;
        b40 = '0;
        a20 = '0;
        b20 = '0;

        // Reset holds z at zero even with inputs that would give +40.
        applyStimulus("reset_hold", 1'b0, {40{1'b1}}, {40{1'b1}}, 20'hFFFFF, 20'hFFFFF);
        checkOutput("reset_const40", z40, 8'h00);
        applyStimulus("release", 1'b1, {40{1'b1}}, {40{1'b1}}, 20'hFFFFF, 20'hFFFFF);
        checkOutput("release_const40", z40, 8'h28);

        applyStimulus("all_zero", 1'b1, 40'h00_0000_0000, 40'h00_0000_0000, 20'h00000, 20'h00000);
        checkOutput("all_zero_const", z40, 8'h28);
        applyStimulus("all_diff", 1'b1, 40'hFF_FFFF_FFFF, 40'h00_0000_0000, 20'hFFFFF, 20'h00000);
        checkOutput("all_diff_const", z40, 8'hD8);
        checkOutput("all_diff20_const", z20, 8'hEC);
        applyStimulus("one_miss", 1'b1, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFE, 20'hFFFFF, 20'hFFFFE);
        checkOutput("one_miss_const", z40, 8'h26);
        applyStimulus("half_miss", 1'b1, 40'hFF_FFFF_FFFF, 40'h00_000F_FFFF, 20'hFFFFF, 20'h003FF);
        checkOutput("half_miss_const", z40, 8'h00);

        // Back-to-back pattern rotation, one result per cycle.
        for (int r = 0; r < 3; r++) begin
            applyStimulus("b2b_p40", 1'b1, 40'h12_3456_789A, 40'h12_3456_789A, 20'h5A5A5, 20'h5A5A5);
            applyStimulus("b2b_m40", 1'b1, 40'h00_0000_0000, 40'hFF_FFFF_FFFF, 20'h00000, 20'hFFFFF);
            applyStimulus("b2b_zero", 1'b1, 40'hFF_FFFF_FFFF, 40'h00_000F_FFFF, 20'hABCDE, 20'h54321);
            applyStimulus("b2b_p38", 1'b1, 40'h80_0000_0000, 40'h00_0000_0000, 20'h80000, 20'h00000);
        end

        // Mid-stream reset discards the in-flight result.
        applyStimulus("pre_reset", 1'b1, 40'hF0_F0F0_F0F0, 40'h0F_0F0F_0F0F, 20'h0F0F0, 20'h00F0F);
        applyStimulus("mid_reset", 1'b0, 40'h00_0000_0000, 40'h00_0000_0000, 20'h00000, 20'h00000);
        checkOutput("mid_reset_const", z40, 8'h00);
        applyStimulus("post_reset", 1'b1, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFE, 20'h12345, 20'h12344);
        checkOutput("post_reset_const", z40, 8'h26);

        // Random sweep; the 20-bit instance covers its full range via the model.
        for (int n = 0; n < 1000; n++) begin
            applyStimulus("rand", 1'b1,
                          {8'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)},
                          20'($urandom), 20'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
